// File: rtl/tlb_cache.sv
// Fully associative first-level TLB: tags are virtual page number plus PCID.
// Lookups answer one cycle after the request. Fills go to a matching entry, else the lowest free entry, else round-robin.
module tlb_cache #(
    parameter int SADDR     = 64,
    parameter int SPCID     = 12,
    parameter int ENTRIES   = 16,
    parameter int PAGE_BITS = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       state,
    input  logic [SADDR-1:0] req_va,
    input  logic [SPCID-1:0] req_pcid,
    input  logic [SADDR-1:0] insert_va,
    input  logic [SADDR-1:0] insert_pa,
    input  logic [SPCID-1:0] insert_pcid,
    output logic [SADDR-1:0] req_ta,
    output logic             hit,
    output logic             miss
);

    localparam int VPNW = SADDR - PAGE_BITS;
    localparam int IDXW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] r_valid;
    logic [VPNW-1:0]    r_vpn  [ENTRIES];
    logic [VPNW-1:0]    r_ppn  [ENTRIES];
    logic [SPCID-1:0]   r_pcid [ENTRIES];
    logic [IDXW-1:0]    r_ptr;

    logic            w_lkHit;
    logic [VPNW-1:0] w_lkPpn;
    logic            w_insMatch;
    logic [IDXW-1:0] w_insMatchIdx;
    logic            w_anyFree;
    logic [IDXW-1:0] w_freeIdx;
    logic [IDXW-1:0] w_insIdx;
    logic            w_unused;

    // The miss flag, the reserved control bits and the page offsets of a fill carry no information here.
    assign w_unused = ^{state[5:3], state[1], insert_va[PAGE_BITS-1:0], insert_pa[PAGE_BITS-1:0]};

    always_comb begin
        w_lkHit = 1'b0;
        w_lkPpn = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_valid[i] && r_vpn[i] == req_va[SADDR-1:PAGE_BITS] && r_pcid[i] == req_pcid) begin
                w_lkHit = 1'b1;
                w_lkPpn = r_ppn[i];
            end
        end
    end

    // The free-slot scan runs downward so that the lowest invalid index is the last one assigned.
    always_comb begin
        w_insMatch    = 1'b0;
        w_insMatchIdx = '0;
        w_anyFree     = 1'b0;
        w_freeIdx     = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && r_vpn[i] == insert_va[SADDR-1:PAGE_BITS] && r_pcid[i] == insert_pcid) begin
                w_insMatch    = 1'b1;
                w_insMatchIdx = IDXW'(i);
            end
            if (!r_valid[i]) begin
                w_anyFree = 1'b1;
                w_freeIdx = IDXW'(i);
            end
        end
        w_insIdx = w_insMatch ? w_insMatchIdx : (w_anyFree ? w_freeIdx : r_ptr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_ptr   <= '0;
            hit     <= 1'b0;
            miss    <= 1'b0;
            req_ta  <= '0;
        end else begin
            if (state[0]) begin
                hit    <= w_lkHit;
                miss   <= !w_lkHit;
                req_ta <= w_lkHit ? {w_lkPpn, req_va[PAGE_BITS-1:0]} : '0;
            end else begin
                hit  <= 1'b0;
                miss <= 1'b0;
            end
            // The pointer only advances when a full TLB forces an eviction.
            if (state[2]) begin
                r_valid[w_insIdx] <= 1'b1;
                r_vpn[w_insIdx]   <= insert_va[SADDR-1:PAGE_BITS];
                r_pcid[w_insIdx]  <= insert_pcid;
                r_ppn[w_insIdx]   <= insert_pa[SADDR-1:PAGE_BITS];
                if (!w_insMatch && !w_anyFree) begin
                    r_ptr <= r_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tlb_cache.sv
// Scoreboard bench for tlb_cache: a behavioural TLB model predicts {hit, miss, req_ta} for every clock edge.
module tb_tlb_cache;

    logic        clk;
    logic        rst;
    logic [5:0]  state;
    logic [63:0] req_va;
    logic [11:0] req_pcid;
    logic [63:0] insert_va;
    logic [63:0] insert_pa;
    logic [11:0] insert_pcid;
    logic [63:0] req_ta;
    logic        hit;
    logic        miss;

    int checkCount = 0;
    int errorCount = 0;

    logic [65:0] expQ[$];
    string       tagQ[$];

    bit          mValid [16];
    logic [51:0] mVpn   [16];
    logic [51:0] mPpn   [16];
    logic [11:0] mPcid  [16];
    int          mPtr;
    logic [63:0] mTa;

    tlb_cache dut (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .req_va     (req_va),
        .req_pcid   (req_pcid),
        .insert_va  (insert_va),
        .insert_pa  (insert_pa),
        .insert_pcid(insert_pcid),
        .req_ta     (req_ta),
        .hit        (hit),
        .miss       (miss)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got hit=%0b miss=%0b ta=%h, expected hit=%0b miss=%0b ta=%h",
                     tag, obs[65], obs[64], obs[63:0], exp[65], exp[64], exp[63:0]);
        end
    endtask

    // Drive one edge's worth of inputs, then let the model predict the registered result of that edge.
    task automatic applyStimulus(input bit doRst, input bit doReq, input bit doIns,
                                 input logic [63:0] rva, input logic [11:0] rpcid,
                                 input logic [63:0] iva, input logic [63:0] ipa,
                                 input logic [11:0] ipcid, input string tag);
        logic [65:0] exp;
        bit          found;
        bit          placed;
        logic [51:0] ppn;
        int          idx;
        rst         = doRst;
        state       = {3'($urandom), doIns, 1'($urandom), doReq};
        req_va      = rva;
        req_pcid    = rpcid;
        insert_va   = iva;
        insert_pa   = ipa;
        insert_pcid = ipcid;
        @(posedge clk);
        if (doRst) begin
            for (int i = 0; i < 16; i++) mValid[i] = 0;
            mPtr = 0;
            mTa  = '0;
            exp  = '0;
        end else begin
            if (doReq) begin
                found = 0;
                ppn   = '0;
                for (int i = 0; i < 16; i++) begin
                    if (mValid[i] && mVpn[i] == rva[63:12] && mPcid[i] == rpcid) begin
                        found = 1;
                        ppn   = mPpn[i];
                    end
                end
                mTa = found ? {ppn, rva[11:0]} : 64'h0;
                exp = {found, !found, mTa};
            end else begin
                exp = {2'b00, mTa};
            end
            if (doIns) begin
                placed = 0;
                idx    = -1;
                for (int i = 0; i < 16; i++) begin
                    if (!placed && mValid[i] && mVpn[i] == iva[63:12] && mPcid[i] == ipcid) begin
                        idx = i;
                        placed = 1;
                    end
                end
                for (int i = 0; i < 16; i++) begin
                    if (!placed && !mValid[i]) begin
                        idx = i;
                        placed = 1;
                    end
                end
                if (!placed) begin
                    idx  = mPtr;
                    mPtr = (mPtr + 1) % 16;
                end
                mValid[idx] = 1;
                mVpn[idx]   = iva[63:12];
                mPcid[idx]  = ipcid;
                mPpn[idx]   = ipa[63:12];
            end
        end
        expQ.push_back(exp);
        tagQ.push_back(tag);
        @(negedge clk);
    endtask

    task automatic doReq(input logic [63:0] va, input logic [11:0] pcid, input string tag);
        applyStimulus(0, 1, 0, va, pcid, 64'h0, 64'h0, 12'h0, tag);
    endtask

    task automatic doIns(input logic [63:0] va, input logic [63:0] pa, input logic [11:0] pcid);
        applyStimulus(0, 0, 1, 64'h0, 12'h0, va, pa, pcid, "insertCycle");
    endtask

    // Outputs are compared on the falling edge, where the MMU would sample them.
    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            checkOutput(tagQ.pop_front(), {hit, miss, req_ta}, expQ.pop_front());
        end
    end

    initial begin
        clk = 0;
        rst = 1;
        state = '0;
        req_va = '0;
        req_pcid = '0;
        insert_va = '0;
        insert_pa = '0;
        insert_pcid = '0;
        mPtr = 0;
        mTa = '0;
        for (int i = 0; i < 16; i++) mValid[i] = 0;

        applyStimulus(1, 0, 0, 64'h0, 12'h0, 64'h0, 64'h0, 12'h0, "reset");
        applyStimulus(1, 0, 0, 64'h0, 12'h0, 64'h0, 64'h0, 12'h0, "reset");
        doReq(64'hFFFF_FFFF_FFFF_FFF1, 12'h0, "missAfterReset");

        doIns(64'h0000_0000_0000_1000, 64'h0000_0000_ABCD_E000, 12'h0);
        doReq(64'h1234, 12'h0, "hitPcid0");
        applyStimulus(0, 0, 0, 64'h0, 12'h0, 64'h0, 64'h0, 12'h0, "holdTa");
        doReq(64'h1234, 12'h5, "missPcid5");

        applyStimulus(1, 0, 0, 64'h0, 12'h0, 64'h0, 64'h0, 12'h0, "reset2");
        for (int i = 0; i < 16; i++) begin
            doIns({52'(i), 12'h0}, {52'(32'h100 + i), 12'hABC}, 12'h0);
        end
        doIns({52'h20, 12'h0}, {52'h120, 12'h0}, 12'h0);
        doReq({52'h0, 12'h010}, 12'h0, "evictVpn0");
        doReq({52'h20, 12'h020}, 12'h0, "hitVpn20");
        doReq({52'h1, 12'h030}, 12'h0, "hitVpn1");
        doIns({52'h21, 12'h0}, {52'h121, 12'h0}, 12'h0);
        doReq({52'h1, 12'h040}, 12'h0, "evictVpn1");
        doReq({52'h21, 12'hFFF}, 12'h0, "hitVpn21");

        doIns({52'h3, 12'h0}, {52'h999, 12'h0}, 12'h0);
        doReq({52'h3, 12'h5A5}, 12'h0, "reinsVpn3");
        for (int i = 2; i < 16; i++) begin
            if (i != 3) doReq({52'(i), 12'(i)}, 12'h0, "keepVpn");
        end

        applyStimulus(0, 1, 1, {52'h40, 12'h111}, 12'h0, {52'h40, 12'h0}, {52'h140, 12'h0}, 12'h0, "sameEdge");
        doReq({52'h40, 12'h222}, 12'h0, "afterInsert");
        doReq({52'h2, 12'h0}, 12'h0, "evictVpn2");

        doIns({52'h40, 12'h0}, {52'h777, 12'h0}, 12'h9);
        doReq({52'h40, 12'h333}, 12'h9, "pcid9Entry");
        doReq({52'h40, 12'h444}, 12'h0, "pcid0Entry");
        doReq({52'h40, 12'h555}, 12'h3, "pcid3Miss");

        applyStimulus(1, 1, 1, {52'h40, 12'h0}, 12'h0, {52'h50, 12'h0}, {52'h150, 12'h0}, 12'h0, "resetOverride");
        applyStimulus(0, 0, 0, 64'h0, 12'h0, 64'h0, 64'h0, 12'h0, "postResetIdle");
        doReq({52'h40, 12'h0}, 12'h0, "missAfterReset2");
        doReq({52'h5, 12'h0}, 12'h0, "missVpn5");
        doReq({52'h50, 12'h0}, 12'h0, "missVpn50");

        repeat (2) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
